// File: rtl/frame_payload_extractor.sv
// Frame body parser that sits behind the AA-BB-CC sync detector: reads length, streams the
// payload with first/last markers, verifies the 8-bit additive checksum and keeps frame statistics.
module frame_payload_extractor #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data,
    input  logic             flag,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic             busy,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LEN     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] CHK     = 2'd3;

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       outData_q, outData_d;
    logic             outValid_q, outValid_d;
    logic             outFirst_q, outFirst_d;
    logic             outLast_q, outLast_d;
    logic             frameOk_q, frameOk_d;
    logic             frameErr_q, frameErr_d;
    logic [1:0]       errCode_q, errCode_d;
    logic [CNT_W-1:0] okCnt_q, okCnt_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        outData_d  = outData_q;
        outValid_d = 1'b0;
        outFirst_d = 1'b0;
        outLast_d  = 1'b0;
        frameOk_d  = 1'b0;
        frameErr_d = 1'b0;
        errCode_d  = errCode_q;
        okCnt_d    = okCnt_q;
        errCnt_d   = errCnt_q;

        // flag only matters in IDLE, so sync words inside a frame body never restart parsing
        case (state_q)
            IDLE: begin
                if (flag) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (data == 8'd0 || data > MAX_LEN_B) begin
                    frameErr_d = 1'b1;
                    errCode_d  = 2'b01;
                    errCnt_d   = (errCnt_q == CNT_MAX) ? errCnt_q : errCnt_q + 1'b1;
                    state_d    = IDLE;
                end else begin
                    len_d   = data;
                    sum_d   = data;
                    cnt_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                outData_d  = data;
                outValid_d = 1'b1;
                outFirst_d = (cnt_q == '0);
                sum_d      = sum_q + data;
                cnt_d      = cnt_q + 1'b1;
                if (8'(cnt_q) == len_q - 8'd1) begin
                    outLast_d = 1'b1;
                    state_d   = CHK;
                end
            end
            default: begin
                if (data == sum_q) begin
                    frameOk_d = 1'b1;
                    errCode_d = 2'b00;
                    okCnt_d   = (okCnt_q == CNT_MAX) ? okCnt_q : okCnt_q + 1'b1;
                end else begin
                    frameErr_d = 1'b1;
                    errCode_d  = 2'b10;
                    errCnt_d   = (errCnt_q == CNT_MAX) ? errCnt_q : errCnt_q + 1'b1;
                end
                state_d = IDLE;
            end
        endcase
    end

    // A mid-frame reset drops the frame silently: no pulse and no counter update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outFirst_q <= 1'b0;
            outLast_q  <= 1'b0;
            frameOk_q  <= 1'b0;
            frameErr_q <= 1'b0;
            errCode_q  <= '0;
            okCnt_q    <= '0;
            errCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outFirst_q <= outFirst_d;
            outLast_q  <= outLast_d;
            frameOk_q  <= frameOk_d;
            frameErr_q <= frameErr_d;
            errCode_q  <= errCode_d;
            okCnt_q    <= okCnt_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_first = outFirst_q;
    assign out_last  = outLast_q;
    assign frame_ok  = frameOk_q;
    assign frame_err = frameErr_q;
    assign err_code  = errCode_q;
    assign busy      = (state_q != IDLE);
    assign ok_cnt    = okCnt_q;
    assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_frame_payload_extractor.sv
// Bench for frame_payload_extractor: directed vector table for the documented frames and
// corner cases, then randomized frames checked against a frame-level reference model.
module tb_frame_payload_extractor;

    localparam int MAX_LEN = 16;

    typedef struct {
        logic       rstn;
        logic       flag;
        logic [7:0] data;
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       ok;
        logic       err;
        int         code;
        logic       busy;
        int         okc;
        int         errc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic        flag;
    logic [7:0]  out_data;
    logic        out_valid, out_first, out_last, frame_ok, frame_err, busy;
    logic [1:0]  err_code;
    logic [15:0] ok_cnt, err_cnt;

    logic [7:0]  sOutData;
    logic        sValid, sFirst, sLast, sOk, sErr, sBusy;
    logic [1:0]  sCode;
    logic [1:0]  sOkCnt, sErrCnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    int mOk, mErr, mCode;
    logic [7:0] mHeld;

    frame_payload_extractor #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .flag(flag),
        .out_data(out_data), .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    // Narrow-counter copy on the same stream, used to watch counter saturation
    frame_payload_extractor #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .data(data), .flag(flag),
        .out_data(sOutData), .out_valid(sValid), .out_first(sFirst), .out_last(sLast),
        .frame_ok(sOk), .frame_err(sErr), .err_code(sCode), .busy(sBusy),
        .ok_cnt(sOkCnt), .err_cnt(sErrCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void row(input logic rstn, input logic fl, input logic [7:0] dt,
                                input logic v, input logic [7:0] d, input logic f, input logic l,
                                input logic ok, input logic err, input int code, input logic bsy,
                                input int okc, input int errc);
        vec_t r;
        r.rstn = rstn; r.flag = fl; r.data = dt;
        r.v = v; r.d = d; r.f = f; r.l = l; r.ok = ok; r.err = err;
        r.code = code; r.busy = bsy; r.okc = okc; r.errc = errc;
        vecs.push_back(r);
    endfunction

    // Frame-level reference: every byte row carries the outputs the rules say must follow it
    function automatic void idleByte(input logic [7:0] dt, input logic fl, input logic bsy);
        row(1'b1, fl, dt, 1'b0, mHeld, 1'b0, 1'b0, 1'b0, 1'b0, mCode, bsy, mOk, mErr);
    endfunction

    function automatic void randomFrame();
        int gap, len, sum, chk;
        logic [7:0] b;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) idleByte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        idleByte(8'hAA, 1'b0, 1'b0);
        idleByte(8'hBB, 1'b0, 1'b0);
        idleByte(8'hCC, 1'b1, 1'b1);
        if ($urandom_range(0, 6) == 0) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            mErr++;
            mCode = 1;
            row(1'b1, 1'($urandom_range(0, 1)), 8'(len), 1'b0, mHeld, 1'b0, 1'b0, 1'b0, 1'b1,
                1, 1'b0, mOk, mErr);
            return;
        end
        len = $urandom_range(1, MAX_LEN);
        sum = len;
        idleByte(8'(len), 1'($urandom_range(0, 3) == 0), 1'b1);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            sum = (sum + int'(b)) % 256;
            mHeld = b;
            row(1'b1, 1'($urandom_range(0, 3) == 0), b, 1'b1, b, 1'(i == 0), 1'(i == len - 1),
                1'b0, 1'b0, mCode, 1'b1, mOk, mErr);
        end
        if ($urandom_range(0, 3) != 0) begin
            mOk++;
            mCode = -1;
            row(1'b1, 1'($urandom_range(0, 1)), 8'(sum), 1'b0, mHeld, 1'b0, 1'b0, 1'b1, 1'b0,
                -1, 1'b0, mOk, mErr);
        end else begin
            chk = (sum + $urandom_range(1, 255)) % 256;
            mErr++;
            mCode = 2;
            row(1'b1, 1'($urandom_range(0, 1)), 8'(chk), 1'b0, mHeld, 1'b0, 1'b0, 1'b0, 1'b1,
                2, 1'b0, mOk, mErr);
        end
    endfunction

    task automatic checkOutput(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d actual %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t r);
        rst_n = r.rstn;
        flag  = r.flag;
        data  = r.data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flag  = 1'b0;
        data  = 8'h00;

        // reset (r f data | v d f l ok err code busy okc errc)
        row(0,0,8'h00, 0,8'h00,0,0,0,0, 0,0,0,0);
        row(0,0,8'h00, 0,8'h00,0,0,0,0, 0,0,0,0);
        // good frame AA BB CC 03 11 22 33 69
        row(1,0,8'hAA, 0,8'h00,0,0,0,0, 0,0,0,0);
        row(1,0,8'hBB, 0,8'h00,0,0,0,0, 0,0,0,0);
        row(1,1,8'hCC, 0,8'h00,0,0,0,0, 0,1,0,0);
        row(1,0,8'h03, 0,8'h00,0,0,0,0, 0,1,0,0);
        row(1,0,8'h11, 1,8'h11,1,0,0,0, 0,1,0,0);
        row(1,0,8'h22, 1,8'h22,0,0,0,0, 0,1,0,0);
        row(1,0,8'h33, 1,8'h33,0,1,0,0, 0,1,0,0);
        row(1,0,8'h69, 0,8'h33,0,0,1,0,-1,0,1,0);
        row(1,0,8'h00, 0,8'h33,0,0,0,0,-1,0,1,0);
        // bad checksum 68
        row(1,0,8'hAA, 0,8'h33,0,0,0,0,-1,0,1,0);
        row(1,0,8'hBB, 0,8'h33,0,0,0,0,-1,0,1,0);
        row(1,1,8'hCC, 0,8'h33,0,0,0,0,-1,1,1,0);
        row(1,0,8'h03, 0,8'h33,0,0,0,0,-1,1,1,0);
        row(1,0,8'h11, 1,8'h11,1,0,0,0,-1,1,1,0);
        row(1,0,8'h22, 1,8'h22,0,0,0,0,-1,1,1,0);
        row(1,0,8'h33, 1,8'h33,0,1,0,0,-1,1,1,0);
        row(1,0,8'h68, 0,8'h33,0,0,0,1, 2,0,1,1);
        row(1,0,8'h00, 0,8'h33,0,0,0,0, 2,0,1,1);
        // length 00
        row(1,0,8'hAA, 0,8'h33,0,0,0,0, 2,0,1,1);
        row(1,0,8'hBB, 0,8'h33,0,0,0,0, 2,0,1,1);
        row(1,1,8'hCC, 0,8'h33,0,0,0,0, 2,1,1,1);
        row(1,0,8'h00, 0,8'h33,0,0,0,1, 1,0,1,2);
        // length 20 (> MAX_LEN)
        row(1,0,8'hAA, 0,8'h33,0,0,0,0, 1,0,1,2);
        row(1,0,8'hBB, 0,8'h33,0,0,0,0, 1,0,1,2);
        row(1,1,8'hCC, 0,8'h33,0,0,0,0, 1,1,1,2);
        row(1,0,8'h20, 0,8'h33,0,0,0,1, 1,0,1,3);
        // embedded sync word: 05 AA BB CC 01 02, checksum 05+AA+BB+CC+01+02 = 0x39
        row(1,0,8'hAA, 0,8'h33,0,0,0,0, 1,0,1,3);
        row(1,0,8'hBB, 0,8'h33,0,0,0,0, 1,0,1,3);
        row(1,1,8'hCC, 0,8'h33,0,0,0,0, 1,1,1,3);
        row(1,0,8'h05, 0,8'h33,0,0,0,0, 1,1,1,3);
        row(1,0,8'hAA, 1,8'hAA,1,0,0,0, 1,1,1,3);
        row(1,0,8'hBB, 1,8'hBB,0,0,0,0, 1,1,1,3);
        row(1,1,8'hCC, 1,8'hCC,0,0,0,0, 1,1,1,3);
        row(1,0,8'h01, 1,8'h01,0,0,0,0, 1,1,1,3);
        row(1,0,8'h02, 1,8'h02,0,1,0,0, 1,1,1,3);
        row(1,0,8'h39, 0,8'h02,0,0,1,0,-1,0,2,3);
        // reset after the 2nd payload byte
        row(1,0,8'hAA, 0,8'h02,0,0,0,0,-1,0,2,3);
        row(1,0,8'hBB, 0,8'h02,0,0,0,0,-1,0,2,3);
        row(1,1,8'hCC, 0,8'h02,0,0,0,0,-1,1,2,3);
        row(1,0,8'h03, 0,8'h02,0,0,0,0,-1,1,2,3);
        row(1,0,8'h11, 1,8'h11,1,0,0,0,-1,1,2,3);
        row(1,0,8'h22, 1,8'h22,0,0,0,0,-1,1,2,3);
        row(0,0,8'h33, 0,8'h00,0,0,0,0, 0,0,0,0);
        // back-to-back len=1 frames; flag on the first checksum byte must be ignored
        row(1,0,8'hAA, 0,8'h00,0,0,0,0, 0,0,0,0);
        row(1,0,8'hBB, 0,8'h00,0,0,0,0, 0,0,0,0);
        row(1,1,8'hCC, 0,8'h00,0,0,0,0, 0,1,0,0);
        row(1,0,8'h01, 0,8'h00,0,0,0,0, 0,1,0,0);
        row(1,0,8'h7F, 1,8'h7F,1,1,0,0, 0,1,0,0);
        row(1,1,8'h80, 0,8'h7F,0,0,1,0,-1,0,1,0);
        row(1,0,8'hAA, 0,8'h7F,0,0,0,0,-1,0,1,0);
        row(1,0,8'hBB, 0,8'h7F,0,0,0,0,-1,0,1,0);
        row(1,1,8'hCC, 0,8'h7F,0,0,0,0,-1,1,1,0);
        row(1,0,8'h01, 0,8'h7F,0,0,0,0,-1,1,1,0);
        row(1,0,8'h7F, 1,8'h7F,1,1,0,0,-1,1,1,0);
        row(1,0,8'h80, 0,8'h7F,0,0,1,0,-1,0,2,0);
        row(1,0,8'h00, 0,8'h7F,0,0,0,0,-1,0,2,0);

        // randomized frames after a fresh reset
        mOk = 0; mErr = 0; mCode = 0; mHeld = 8'h00;
        row(0,0,8'h00, 0,8'h00,0,0,0,0, 0,0,0,0);
        for (int k = 0; k < 80; k++) randomFrame();
        idleByte(8'h00, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput("out_valid", i, int'(out_valid), int'(vecs[i].v));
            checkOutput("out_data", i, int'(out_data), int'(vecs[i].d));
            if (vecs[i].v) begin
                checkOutput("out_first", i, int'(out_first), int'(vecs[i].f));
                checkOutput("out_last", i, int'(out_last), int'(vecs[i].l));
            end
            checkOutput("frame_ok", i, int'(frame_ok), int'(vecs[i].ok));
            checkOutput("frame_err", i, int'(frame_err), int'(vecs[i].err));
            if (vecs[i].code >= 0) checkOutput("err_code", i, int'(err_code), vecs[i].code);
            checkOutput("busy", i, int'(busy), int'(vecs[i].busy));
            checkOutput("ok_cnt", i, int'(ok_cnt), vecs[i].okc);
            checkOutput("err_cnt", i, int'(err_cnt), vecs[i].errc);
            checkOutput("sat_ok_cnt", i, int'(sOkCnt), (vecs[i].okc > 3) ? 3 : vecs[i].okc);
            checkOutput("sat_err_cnt", i, int'(sErrCnt), (vecs[i].errc > 3) ? 3 : vecs[i].errc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
